// File: rtl/sev_seg_scan_decoder_if.sv
// Scanned seven-segment bus: segment lines plus one-hot digit select.
interface sev_seg_scan_decoder_if #(
    parameter int unsigned NUM_DIG = 5
);
    logic [7:0]         sev_data;
    logic [NUM_DIG-1:0] sev_sel;

    modport master (output sev_data, output sev_sel);
    modport slave  (input  sev_data, input  sev_sel);
endinterface

// File: rtl/sev_seg_scan_decoder.sv
// Receive side of the multiplexed seven-segment display bus.
// Samples the scanned segment/select lines, de-ghosts each digit, maps segment
// patterns back to hex values and assembles complete frames.
// Optional feature macro: SEV_DEC_ERR_CNT_EN adds a saturating error counter port.
module sev_seg_scan_decoder #(
    parameter int unsigned NUM_DIG    = 5,
    parameter int unsigned STABLE_CNT = 4,
    parameter bit          SEG_ACT_LO = 1'b0,
    parameter int unsigned CAP_POS    = 3,
    parameter int unsigned LOC_POS    = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    sev_seg_scan_decoder_if.slave  sev_if,
    output logic [4*NUM_DIG-1:0]   digits_o,
    output logic [NUM_DIG-1:0]     dps_o,
    output logic [2:0]             capacity_o,
    output logic [2:0]             best_place_o,
    output logic                   frame_valid_o,
    output logic                   pattern_err_o,
    output logic                   sel_err_o
`ifdef SEV_DEC_ERR_CNT_EN
    ,
    output logic [7:0]             err_count_o
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DIG_W = 4 * NUM_DIG;

    // Segment pattern to hex value; bit 4 flags a legal pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    logic [7:0]         s1_data_q;
    logic [NUM_DIG-1:0] s1_sel_q;

    logic [7:0]         prev_data_q;
    logic [NUM_DIG-1:0] prev_sel_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic               same_c, onehot_c, multi_c;

    logic [DIG_W-1:0]   shadow_val_q, shadow_val_d;
    logic [NUM_DIG-1:0] shadow_dp_q, shadow_dp_d;
    logic [NUM_DIG-1:0] seen_q, seen_d;
    logic [DIG_W-1:0]   digits_q, digits_d;
    logic [NUM_DIG-1:0] dps_q, dps_d;
    logic [2:0]         cap_q, cap_d;
    logic [2:0]         loc_q, loc_d;
    logic               fv_q, fv_d;
    logic               perr_q, perr_d;
    logic               serr_q;
    logic [4:0]         dec_c;

    // Input register, normalising polarity to active-high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_data_q <= '0;
            s1_sel_q  <= '0;
        end else if (SEG_ACT_LO) begin
            s1_data_q <= ~sev_if.sev_data;
            s1_sel_q  <= ~sev_if.sev_sel;
        end else begin
            s1_data_q <= sev_if.sev_data;
            s1_sel_q  <= sev_if.sev_sel;
        end
    end

    // Stability tracking: run counter and a single accept strobe when the run reaches STABLE_CNT.
    always_comb begin
        same_c   = (s1_data_q == prev_data_q) && (s1_sel_q == prev_sel_q);
        onehot_c = (s1_sel_q != '0) && ((s1_sel_q & (s1_sel_q - NUM_DIG'(1))) == '0);
        multi_c  = (s1_sel_q != '0) && !onehot_c;
        cnt_d    = CNT_W'(1);
        acc_d    = 1'b0;
        if (same_c) begin
            cnt_d = (cnt_q >= CNT_W'(STABLE_CNT)) ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (onehot_c) begin
            acc_d = same_c ? (cnt_q == CNT_W'(STABLE_CNT - 1)) : (STABLE_CNT == 1);
        end
    end

    // Stage-2 registers: previous sample, run counter, accept strobe, select error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_data_q <= '0;
            prev_sel_q  <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            serr_q      <= 1'b0;
        end else begin
            prev_data_q <= s1_data_q;
            prev_sel_q  <= s1_sel_q;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            serr_q      <= multi_c;
        end
    end

    // Decode the accepted digit into the shadow frame and latch the frame once every slot is seen.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        seen_d       = seen_q;
        digits_d     = digits_q;
        dps_d        = dps_q;
        cap_d        = cap_q;
        loc_d        = loc_q;
        fv_d         = 1'b0;
        perr_d       = 1'b0;
        dec_c        = seg_decode(prev_data_q[6:0]);
        if (acc_q) begin
            if (dec_c[4]) begin
                for (int unsigned i = 0; i < NUM_DIG; i++) begin
                    if (prev_sel_q[i]) begin
                        shadow_val_d[4*i +: 4] = dec_c[3:0];
                        shadow_dp_d[i]         = prev_data_q[7];
                        seen_d[i]              = 1'b1;
                    end
                end
            end else begin
                perr_d = 1'b1;
            end
        end
        // A digit accepted in the completion cycle still lands in the latched frame.
        if (&seen_q) begin
            digits_d = shadow_val_d;
            dps_d    = shadow_dp_d;
            cap_d    = shadow_val_d[4*CAP_POS +: 3];
            loc_d    = shadow_val_d[4*LOC_POS +: 3];
            fv_d     = 1'b1;
            seen_d   = '0;
        end
    end

    // Shadow frame, seen mask and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            seen_q       <= '0;
            digits_q     <= '0;
            dps_q        <= '0;
            cap_q        <= '0;
            loc_q        <= '0;
            fv_q         <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            seen_q       <= seen_d;
            digits_q     <= digits_d;
            dps_q        <= dps_d;
            cap_q        <= cap_d;
            loc_q        <= loc_d;
            fv_q         <= fv_d;
            perr_q       <= perr_d;
        end
    end

    assign digits_o      = digits_q;
    assign dps_o         = dps_q;
    assign capacity_o    = cap_q;
    assign best_place_o  = loc_q;
    assign frame_valid_o = fv_q;
    assign pattern_err_o = perr_q;
    assign sel_err_o     = serr_q;

`ifdef SEV_DEC_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [8:0] err_sum_c;

    // Saturating error total; both error kinds in one cycle add two.
    always_comb begin
        err_sum_c = 9'(err_cnt_q) + 9'(perr_d) + 9'(multi_c);
        err_cnt_d = err_sum_c[8] ? 8'hFF : err_sum_c[7:0];
    end

    // Error counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_sev_seg_scan_decoder.sv
// Randomised self-checking bench for sev_seg_scan_decoder with a frame-level reference model.
module tb_sev_seg_scan_decoder;

    localparam int unsigned N   = 5;
    localparam int unsigned S   = 4;
    localparam int unsigned CAP = 3;
    localparam int unsigned LOC = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sev_seg_scan_decoder_if #(.NUM_DIG(N)) bus ();

    logic [4*N-1:0] digits;
    logic [N-1:0]   dps;
    logic [2:0]     capacity, best_place;
    logic           frame_valid, pattern_err, sel_err;
`ifdef SEV_DEC_ERR_CNT_EN
    logic [7:0]     err_count;
`endif

    sev_seg_scan_decoder #(
        .NUM_DIG(N), .STABLE_CNT(S), .SEG_ACT_LO(1'b0), .CAP_POS(CAP), .LOC_POS(LOC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sev_if        (bus.slave),
        .digits_o      (digits),
        .dps_o         (dps),
        .capacity_o    (capacity),
        .best_place_o  (best_place),
        .frame_valid_o (frame_valid),
        .pattern_err_o (pattern_err),
        .sel_err_o     (sel_err)
`ifdef SEV_DEC_ERR_CNT_EN
        ,
        .err_count_o   (err_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: history of bus samples with run lengths, plus the frame being assembled.
    typedef struct packed {
        logic [7:0]   d;
        logic [N-1:0] s;
        logic         acc;
        logic         bad;
    } smp_t;

    logic [6:0]     seg_lut [16];
    smp_t           hq [$];
    logic [7:0]     last_d;
    logic [N-1:0]   last_s;
    int             run;
    logic [3:0]     m_val [N];
    logic           m_dp [N];
    logic [N-1:0]   m_seen;
    logic [4*N-1:0] e_digits;
    logic [N-1:0]   e_dps;
    logic [2:0]     e_cap, e_loc;
    logic           e_fv, e_perr, e_serr;
    int             e_err;

    int n_fv, n_perr, n_serr;

    function automatic int lut_find(input logic [6:0] seg);
        for (int k = 0; k < 16; k++) if (seg_lut[k] == seg) return k;
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [7:0] d, input logic [N-1:0] s);
        smp_t a, b, nw;
        int   idx;
        logic complete;
        if (r) begin
            hq.delete();
            hq.push_back('0);
            hq.push_back('0);
            last_d = '0; last_s = '0; run = 1;
            for (int i = 0; i < N; i++) begin m_val[i] = '0; m_dp[i] = 1'b0; end
            m_seen = '0; e_digits = '0; e_dps = '0; e_cap = '0; e_loc = '0;
            e_fv = 0; e_perr = 0; e_serr = 0; e_err = 0;
            return;
        end
        a = hq[hq.size()-2];
        b = hq[hq.size()-1];
        complete = (m_seen == {N{1'b1}});
        e_fv = 0; e_perr = 0;
        if (a.acc) begin
            idx = lut_find(a.d[6:0]);
            if (idx >= 0) begin
                for (int i = 0; i < N; i++) if (a.s[i]) begin
                    m_val[i] = 4'(idx); m_dp[i] = a.d[7]; m_seen[i] = 1'b1;
                end
            end else e_perr = 1;
        end
        if (complete) begin
            for (int i = 0; i < N; i++) begin e_digits[4*i +: 4] = m_val[i]; e_dps[i] = m_dp[i]; end
            e_cap = m_val[CAP][2:0];
            e_loc = m_val[LOC][2:0];
            e_fv = 1;
            m_seen = '0;
        end
        e_serr = b.bad;
        e_err = e_err + int'(e_perr) + int'(e_serr);
        if (e_err > 255) e_err = 255;
        if (d == last_d && s == last_s) begin
            if (run < 1000) run++;
        end else run = 1;
        last_d = d; last_s = s;
        nw.d = d; nw.s = s;
        nw.acc = (run == S) && ($countones(s) == 1);
        nw.bad = ($countones(s) > 1);
        hq.push_back(nw);
        if (hq.size() > 4) void'(hq.pop_front());
    endtask

    // One clock: drive the bus, advance the model on the edge, compare just after it.
    task automatic step(input logic r, input logic [7:0] d, input logic [N-1:0] s);
        rst = r; bus.sev_data = d; bus.sev_sel = s;
        @(posedge clk);
        model_edge(r, d, s);
        #1;
        check("digits", 32'(digits), 32'(e_digits));
        check("dps", 32'(dps), 32'(e_dps));
        check("capacity", 32'(capacity), 32'(e_cap));
        check("best_place", 32'(best_place), 32'(e_loc));
        check("frame_valid", 32'(frame_valid), 32'(e_fv));
        check("pattern_err", 32'(pattern_err), 32'(e_perr));
        check("sel_err", 32'(sel_err), 32'(e_serr));
`ifdef SEV_DEC_ERR_CNT_EN
        check("err_count", 32'(err_count), 32'(e_err));
`endif
        if (frame_valid) n_fv++;
        if (pattern_err) n_perr++;
        if (sel_err) n_serr++;
    endtask

    task automatic hold(input int len, input logic [7:0] d, input logic [N-1:0] s);
        repeat (len) step(1'b0, d, s);
    endtask

    logic [7:0] frame_pat [N];

    initial begin
        seg_lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        frame_pat = '{8'h3F, 8'h4F, 8'h3F, 8'h3F, 8'h5B};

        // Reset with a random bus, then quiet cycles.
        repeat (3) step(1'b1, 8'($urandom), N'($urandom));
        hold(2, 8'h00, '0);

        // Full frame scan, 8 cycles per digit.
        n_fv = 0;
        for (int i = 0; i < N; i++) hold(8, frame_pat[i], N'(1) << i);
        hold(3, 8'h00, '0);
        check("scan_frames", 32'(n_fv), 32'd1);

        // Short glitch of an 8 before a stable 1 on digit 0.
        n_perr = 0;
        hold(2, 8'h7F, N'(1));
        hold(8, 8'h06, N'(1));
        hold(3, 8'h00, '0);
        check("glitch_perr", 32'(n_perr), 32'd0);

        // Undecodable pattern held stable.
        n_perr = 0;
        hold(8, 8'h55, N'(4));
        hold(3, 8'h00, '0);
        check("illegal_perr", 32'(n_perr), 32'd1);

        // Multi-hot select held for six cycles.
        n_serr = 0;
        hold(6, 8'h06, N'(3));
        hold(3, 8'h00, '0);
        check("multi_serr", 32'(n_serr), 32'd6);

        // Reset after three accepted digits, then a full scan.
        for (int i = 0; i < 3; i++) hold(8, 8'h66, N'(1) << i);
        step(1'b1, 8'h00, '0);
        n_fv = 0;
        for (int i = 0; i < N; i++) hold(8, frame_pat[(i + 1) % N], N'(1) << i);
        hold(3, 8'h00, '0);
        check("post_rst_frames", 32'(n_fv), 32'd1);

        // Randomised scanning with glitches, blanking, bad selects and rare resets.
        for (int r = 0; r < 400; r++) begin
            int unsigned k;
            logic [7:0]   d;
            logic [N-1:0] s;
            k = $urandom_range(0, 99);
            if (k < 72) s = N'(1) << $urandom_range(0, N - 1);
            else if (k < 86) s = '0;
            else s = N'(3) << $urandom_range(0, N - 2);
            if ($urandom_range(0, 9) < 8) d = {1'($urandom), seg_lut[$urandom_range(0, 15)]};
            else d = 8'($urandom);
            if ($urandom_range(0, 199) == 0) step(1'b1, d, s);
            hold(int'($urandom_range(1, 10)), d, s);
        end
        hold(8, 8'h00, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
